// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC and fetches one instruction per PC.
// Non-pipelined; at most one imem fetch is in flight.
// The optional misaligned-PC trap is enabled by defining FETCH_ALIGN_CHECK_EN.
// In the default build, the low two PC bits are forced to zero on load.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc_in,
    output logic [31:0]      pc_out,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             fetch_misalign
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t state;
    state_t state_nxt;
    logic   handoff;
    logic   npc_misaligned;

    assign handoff        = (state == S_HOLD) && instr_ready;
    assign npc_misaligned = (npc_in[1:0] != 2'b00);

    // State register; reset returns to issuing a fetch at RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; inputs that arrive in the wrong state are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:  if (imem_ready)  state_nxt = S_WAIT;
            S_WAIT: if (imem_rvalid) state_nxt = S_HOLD;
            S_HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    state_nxt = npc_misaligned ? S_ERR : S_REQ;
`else
                    state_nxt = S_REQ;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_ERR:  state_nxt = S_ERR;
`endif
            default: state_nxt = S_REQ;
        endcase
    end

    // Request is gated by rst so nothing is presented to imem during reset.
    assign imem_req    = (state == S_REQ) && !rst;
    assign imem_addr   = pc_out;
    assign instr_valid = (state == S_HOLD);

    // PC register: loads the next-PC result only on the handoff cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out <= RESET_PC;
        end else if (handoff) begin
`ifdef FETCH_ALIGN_CHECK_EN
            pc_out <= npc_in;
`else
            pc_out <= {npc_in[31:2], 2'b00};
`endif
        end
    end

    // Instruction register: captured once per fetch, held under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out <= '0;
        end else if ((state == S_WAIT) && imem_rvalid) begin
            instr_out <= imem_rdata;
        end
    end

    // Saturating count of cycles spent requesting or waiting on imem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (((state == S_REQ) || (state == S_WAIT)) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_misalign <= 1'b0;
        end else if (handoff && npc_misaligned) begin
            fetch_misalign <= 1'b1;
        end
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = npc_misaligned;
    assign fetch_misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc_in;
    logic [31:0] pc_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] stall_cnt;
    logic        fetch_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .npc_in(npc_in), .pc_out(pc_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stall_cnt(stall_cnt),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; npc_in = 32'hDEAD_BEEF; imem_ready = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = 32'h0; instr_ready = 1'b0;
        step(); step();
        n_checks++; if (pc_out !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h3000); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0 || instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %b/%h exp 0/0", instr_valid, instr_out); end
        n_checks++; if (stall_cnt !== 16'd0 || fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_cnt got %0d/%b exp 0/0", stall_cnt, fetch_misalign); end
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL first_req got %b/%h exp 1/00003000", imem_req, imem_addr); end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_state got %b/%b exp 0/0", imem_req, instr_valid); end
        step();
        imem_rvalid = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h2008_0005) begin n_fail++; $display("FAIL first_instr got %b/%h exp 1/20080005", instr_valid, instr_out); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL first_cnt got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_handoff();
        instr_ready = 1'b1; npc_in = 32'h3004;
        step();
        instr_ready = 1'b0; npc_in = 32'hFFFF_FFFF;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || pc_out !== 32'h3004) begin n_fail++; $display("FAIL handoff_req got %b/%h exp 1/00003004", imem_req, imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL handoff_valid got %b exp 0", instr_valid); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL handoff_cnt got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL stall_req[%0d] got %b/%h exp 1/00003004", i, imem_req, imem_addr); end
        end
        n_checks++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL stall_cnt got %0d exp 6", stall_cnt); end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        step();
        imem_rvalid = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h1111_2222 || stall_cnt !== 16'd8) begin n_fail++; $display("FAIL stall_fetch got %b/%h/%0d exp 1/11112222/8", instr_valid, instr_out, stall_cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            // Stray responses during hold must not disturb the held word.
            imem_rvalid = (i % 3 == 0); imem_rdata = 32'hBAD0_0000 + i;
            step();
            n_checks++; if (instr_out !== 32'h1111_2222 || pc_out !== 32'h3004 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold[%0d] got %h/%h/%b/%b exp 11112222/00003004/0/1", i, instr_out, pc_out, imem_req, instr_valid); end
        end
        imem_rvalid = 1'b0;
        n_checks++; if (stall_cnt !== 16'd8) begin n_fail++; $display("FAIL hold_cnt got %0d exp 8", stall_cnt); end
    endtask

    task automatic test_reset_mid_fetch();
        instr_ready = 1'b1; npc_in = 32'h3008;
        step();
        instr_ready = 1'b0; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (pc_out !== 32'h3000 || imem_req !== 1'b0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst got %h/%b/%0d exp 00003000/0/0", pc_out, imem_req, stall_cnt); end
        step();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
        #1;
        n_checks++; if (imem_req !== 1'b1 || pc_out !== 32'h3000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst got %b/%h/%b exp 1/00003000/0", imem_req, pc_out, instr_valid); end
        step();
        imem_rvalid = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr_out !== 32'h0) begin n_fail++; $display("FAIL stray_rvalid got %b/%b/%h exp 1/0/0", imem_req, instr_valid, instr_out); end
    endtask

    task automatic test_misalign();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_rvalid = 1'b0; instr_ready = 1'b1; npc_in = 32'h3006;
        step();
        instr_ready = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        step(); step();
        n_checks++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL misalign got %b/%b/%b exp 1/0/0", fetch_misalign, imem_req, instr_valid); end
        n_checks++; if (pc_out !== 32'h3006) begin n_fail++; $display("FAIL misalign_pc got %h exp 00003006", pc_out); end
`else
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL align_pc got %b/%h/%b exp 1/00003004/0", imem_req, imem_addr, fetch_misalign); end
`endif
    endtask

    task automatic test_wrap();
`ifndef FETCH_ALIGN_CHECK_EN
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0; instr_ready = 1'b1; npc_in = 32'h0000_0000;
        step();
        instr_ready = 1'b0;
        n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap got %b/%h exp 1/00000000", imem_req, imem_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_handoff();
        test_req_stall();
        test_backpressure();
        test_reset_mid_fetch();
        test_misalign();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
